adder_hold_sequencer: RTL
=========================

// Module: adder_hold_sequencer
// PURPOSE
//  Sequences the adder hold register: arbitrates between two requesters (decode
//  logic, branch/page-fixup logic), pulses the hold-register load, waits for
//  the target bus to be free, then drives the register's ADL / SB enables for
//  a fixed number of cycles. Sits between the timing/decode logic and the
//  adder hold register.
// PARAMETERS
//  DRIVE_CYCLES  1  cycles the enables stay asserted per transaction (1..7)
//  WAIT_MAX      7  max WAIT cycles before abandoning a transaction (1..7)
// PORTS
//  clk          in   1  system clock (clk_2 domain); all state on rising edge
//  reset        in   1  asynchronous, active-high reset
//  dec_req      in   1  decode requester wants a transaction
//  dec_dest     in   2  00 load only, 01 ADL, 10 SB[7:0], 11 SB[6:0]
//  dec_gnt      out  1  one-cycle grant to decode requester
//  fix_req      in   1  fixup requester wants a transaction
//  fix_dest     in   2  same encoding as dec_dest
//  fix_gnt      out  1  one-cycle grant to fixup requester
//  adl_busy     in   1  another driver owns ADL this cycle
//  sb_busy      in   1  another driver owns SB this cycle
//  load_hold    out  1  hold register captures ALU output this cycle
//  enable_adl   out  1  to hold register enable_adl
//  enable_sb06  out  1  to hold register enable_sb06
//  enable_sb7   out  1  to hold register enable_sb7
//  busy         out  1  high whenever state != IDLE
//  timeout_err  out  1  sticky: a transaction was abandoned in WAIT
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, counters 0, RR pointer -> decode.
//    Reset mid-transaction drops enables immediately; transaction is lost.
//  - All outputs registered (decoded from state/latched dest, no input paths).
//  - States: IDLE, LOAD, WAIT, DRIVE.
//  - IDLE: at an edge with any req high -> LOAD; winner's dest latched;
//    later dest changes ignored. Requester holds req until its gnt, then drops.
//  - Arbitration: both req high -> fix wins (fixed priority).
//  - LOAD (1 cycle): load_hold=1, winner's gnt=1. Next: dest 00 -> IDLE;
//    target bus busy -> WAIT (wait_cnt=1); else -> DRIVE.
//  - Target bus: dest 01 -> adl_busy; dest 10/11 -> sb_busy.
//  - WAIT: target busy and wait_cnt==WAIT_MAX -> set timeout_err, -> IDLE
//    (no drive); target busy otherwise -> stay, wait_cnt++; free -> DRIVE.
//  - DRIVE: held exactly DRIVE_CYCLES cycles, then -> IDLE. Enables:
//    01 enable_adl; 10 enable_sb06+enable_sb7; 11 enable_sb06 only.
//    Busy inputs ignored in DRIVE; never two enables groups for ADL and SB.
//  - Latency (bus free): req seen edge n -> LOAD cycle n+1 -> DRIVE n+2..
//    n+1+DRIVE_CYCLES -> IDLE. Min one IDLE cycle between transactions.
//  - Requests arriving outside IDLE wait; no queueing beyond the req level.
//  - timeout_err clears only on reset.
// CONFIGURATION
//  ADDER_SEQ_RR_EN defined: round-robin arbitration; on simultaneous req the
//    requester not served last wins; pointer updates on each grant.
//  Undefined: fixed priority, fix over dec; pointer logic absent.
// TESTING
//  1 reset mid-DRIVE (dest 01) -> enable_adl, busy low same cycle, state IDLE.
//  2 dec_req, dest 10, busses free, DRIVE_CYCLES=2 -> gnt+load_hold cycle 1,
//    sb06+sb7 cycles 2-3, busy low cycle 4; enable_adl never high.
//  3 fix dest 11, sb_busy high 3 cycles -> WAIT 3 cycles, then only sb06 high.
//  4 dec dest 01, adl_busy held high, WAIT_MAX=7 -> 7 WAIT cycles,
//    timeout_err=1, no enable ever asserted, next request still served.
//  5 dec+fix req together twice, fixed priority -> fix, fix; with
//    ADDER_SEQ_RR_EN -> fix, then dec.
//  6 dest 00 -> single LOAD cycle (load_hold, gnt), no enables, back to IDLE.

Source files
------------

// File: rtl/adder_hold_sequencer.sv
// Adder hold register sequencer: arbitrate, pulse load, wait for target bus, drive ADL/SB enables.
// Define ADDER_SEQ_RR_EN for round-robin arbitration; otherwise fix has fixed priority over dec.
module adder_hold_sequencer #(
    parameter int unsigned DRIVE_CYCLES = 1,
    parameter int unsigned WAIT_MAX     = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec_req,
    input  logic [1:0] dec_dest,
    output logic       dec_gnt,
    input  logic       fix_req,
    input  logic [1:0] fix_dest,
    output logic       fix_gnt,
    input  logic       adl_busy,
    input  logic       sb_busy,
    output logic       load_hold,
    output logic       enable_adl,
    output logic       enable_sb06,
    output logic       enable_sb7,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRIVE} state_t;

    localparam logic [2:0] DRIVE_LAST = 3'(DRIVE_CYCLES);
    localparam logic [2:0] WAIT_LAST  = 3'(WAIT_MAX);

    state_t     state, state_n;
    logic [1:0] dest, dest_n;
    logic [2:0] wait_cnt, wait_cnt_n;
    logic [2:0] drv_cnt, drv_cnt_n;
    logic       timeout_n;
    logic       any_req;
    logic       pick_fix;
    logic       target_busy;

    assign any_req     = dec_req | fix_req;
    assign target_busy = (dest == 2'b01) ? adl_busy : sb_busy;

`ifdef ADDER_SEQ_RR_EN
    logic last_fix;
    // On a tie the requester not served last wins.
    assign pick_fix = fix_req & (~dec_req | ~last_fix);
`else
    assign pick_fix = fix_req;
`endif

    always_comb begin
        state_n    = state;
        dest_n     = dest;
        wait_cnt_n = wait_cnt;
        drv_cnt_n  = drv_cnt;
        timeout_n  = timeout_err;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = LOAD;
                    dest_n  = pick_fix ? fix_dest : dec_dest;
                end
            end
            LOAD: begin
                if (dest == 2'b00) begin
                    state_n = IDLE;
                end else if (target_busy) begin
                    state_n    = WAIT;
                    wait_cnt_n = 3'd1;
                end else begin
                    state_n   = DRIVE;
                    drv_cnt_n = 3'd1;
                end
            end
            WAIT: begin
                if (target_busy) begin
                    if (wait_cnt == WAIT_LAST) begin
                        timeout_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        wait_cnt_n = wait_cnt + 3'd1;
                    end
                end else begin
                    state_n   = DRIVE;
                    drv_cnt_n = 3'd1;
                end
            end
            DRIVE: begin
                if (drv_cnt == DRIVE_LAST) state_n = IDLE;
                else                       drv_cnt_n = drv_cnt + 3'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dest        <= '0;
            wait_cnt    <= '0;
            drv_cnt     <= '0;
            dec_gnt     <= 1'b0;
            fix_gnt     <= 1'b0;
            load_hold   <= 1'b0;
            enable_adl  <= 1'b0;
            enable_sb06 <= 1'b0;
            enable_sb7  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
`ifdef ADDER_SEQ_RR_EN
            last_fix    <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            dest        <= dest_n;
            wait_cnt    <= wait_cnt_n;
            drv_cnt     <= drv_cnt_n;
            dec_gnt     <= (state == IDLE) && any_req && !pick_fix;
            fix_gnt     <= (state == IDLE) && any_req && pick_fix;
            load_hold   <= (state_n == LOAD);
            enable_adl  <= (state_n == DRIVE) && (dest_n == 2'b01);
            enable_sb06 <= (state_n == DRIVE) && dest_n[1];
            enable_sb7  <= (state_n == DRIVE) && (dest_n == 2'b10);
            busy        <= (state_n != IDLE);
            timeout_err <= timeout_n;
`ifdef ADDER_SEQ_RR_EN
            if ((state == IDLE) && any_req) last_fix <= pick_fix;
`endif
        end
    end

endmodule
